// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run controller for the pipelined MIPS core. It sequences the core reset
// pulse, counts executed cycles and register write-backs, and ends a run on
// either a halt (PC unchanged for STALL_LIMIT consecutive cycles) or a
// timeout (MAX_CYCLES cycles spent in RUN). After a run ends, a new start
// clears the status and begins another run.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   reset      synchronous, active-low reset (0 = reset)
//   start      begin a run (pulse or level; sampled in IDLE and DONE only)
//   pc         current fetch PC from the core
//   wb_en      core register-file write enable for a retiring instruction
//   cpu_reset  active-high reset to the core (high outside RUN)
//   running    high while in RUN
//   done       high while in DONE
//   halted     run ended by PC stall
//   timeout    run ended by cycle budget
//   cycle_cnt  completed RUN cycles (saturating)
//   wb_cnt     write-backs counted in RUN (saturating)
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int RESET_CYCLES = 5,
  parameter int MAX_CYCLES   = 20000,
  parameter int STALL_LIMIT  = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      pc,
  input  logic             wb_en,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX     = CNT_W'(MAX_CYCLES);
  localparam logic [STALL_W-1:0] STALL_ONE   = STALL_W'(1);
  localparam logic [STALL_W-1:0] STALL_LIM   = STALL_W'(STALL_LIMIT);
  localparam logic [7:0]         RST_CYCLES  = 8'(RESET_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [7:0]         rst_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic [31:0]        last_pc;
  logic               pc_valid;

  // Values the RUN state would commit this cycle.
  logic [CNT_W-1:0]   cycle_nxt;
  logic [CNT_W-1:0]   wb_nxt;
  logic [STALL_W-1:0] stall_nxt;
  logic               hit_halt;
  logic               hit_timeout;

  always_comb begin
    // NOTE: every signal gets a value before any condition so no latch is
    // inferred when a branch does not assign it.
    cycle_nxt   = cycle_cnt;
    wb_nxt      = wb_cnt;
    stall_nxt   = '0;
    hit_halt    = 1'b0;
    hit_timeout = 1'b0;

    // Counters saturate at all-ones instead of wrapping.
    if (!(&cycle_cnt)) cycle_nxt = cycle_cnt + CNT_ONE;
    if (wb_en && !(&wb_cnt)) wb_nxt = wb_cnt + CNT_ONE;

    // The first RUN cycle has no previous PC, so it can never be a stall.
    // The run ends as soon as the stall count reaches the limit, so it
    // cannot grow past STALL_LIMIT.
    if (pc_valid && (pc == last_pc)) stall_nxt = stall_cnt + STALL_ONE;

    hit_halt    = (stall_nxt == STALL_LIM);
    hit_timeout = (cycle_nxt == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (!reset) begin
      state     <= S_IDLE;
      rst_cnt   <= '0;
      stall_cnt <= '0;
      last_pc   <= '0;
      pc_valid  <= 1'b0;
      cpu_reset <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      halted    <= 1'b0;
      timeout   <= 1'b0;
      cycle_cnt <= '0;
      wb_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cpu_reset <= 1'b1;
          if (start) begin
            state   <= S_RESET;
            rst_cnt <= RST_CYCLES;
          end
        end

        // rst_cnt was loaded on entry; the last RESET cycle is the one that
        // sees a count of one, giving exactly RESET_CYCLES cycles here.
        S_RESET: begin
          if (rst_cnt <= 8'd1) begin
            state     <= S_RUN;
            cpu_reset <= 1'b0;
            running   <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - 8'd1;
          end
        end

        S_RUN: begin
          cycle_cnt <= cycle_nxt;
          wb_cnt    <= wb_nxt;
          stall_cnt <= stall_nxt;
          last_pc   <= pc;
          pc_valid  <= 1'b1;
          if (hit_halt || hit_timeout) begin
            state     <= S_DONE;
            running   <= 1'b0;
            done      <= 1'b1;
            cpu_reset <= 1'b1;
            // A halt in the same cycle as the budget running out wins.
            halted    <= hit_halt;
            timeout   <= hit_timeout && !hit_halt;
          end
        end

        S_DONE: begin
          if (start) begin
            state     <= S_RESET;
            rst_cnt   <= RST_CYCLES;
            done      <= 1'b0;
            halted    <= 1'b0;
            timeout   <= 1'b0;
            cycle_cnt <= '0;
            wb_cnt    <= '0;
            stall_cnt <= '0;
            pc_valid  <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
